frame_mem_host: RTL and testbench

- Memory responder and frame sequencer on the far side of the accelerator data bus (addr/dataR/dataW/en/we) and the start/finish handshake.
- Holds the source image (words 0..W-1) and result image (words W..2W-1) in one single-port synchronous RAM.
- A host loads the source frame over a valid/ready stream, the block runs the accelerator, then streams the result frame back out.

---
 rtl/frame_pkg.sv | 19 +
 rtl/frame_ram.sv | 33 +++
 rtl/frame_mem_host.sv | 231 +++++++++++++++++++++++
 tb/tb_frame_mem_host.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared types and sizing for the frame memory host: state encoding, word type, image geometry.
package frame_pkg;

    localparam int WORDS_PER_IMG = 25344;
    localparam int MEM_WORDS     = 2 * WORDS_PER_IMG;
    localparam int ADDR_W        = 16;

    typedef logic [31:0] word_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT_LOW,
        DUMP,
        DONE
    } state_t;

endpackage

// File: rtl/frame_ram.sv
// Single-port synchronous RAM; writes commit at the edge, read data is registered and held between reads.
module frame_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 50688
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic [AW-1:0]     idx;
    logic              hit;

    assign idx = AW'(addr);
    assign hit = en && (addr < ADDR_W'(DEPTH));

    always_ff @(posedge clk) begin
        if (hit && we) begin
            mem[idx] <= wdata;
        end
        if (hit && !we) begin
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/frame_mem_host.sv
// Frame sequencer: host stream load -> accelerator run -> buffered result dump over one shared RAM.
// Optional sticky address checker enabled by defining FRAME_MEM_ADDR_CHECK_EN.
module frame_mem_host #(
    parameter int WORDS_PER_IMG = frame_pkg::WORDS_PER_IMG,
    parameter int MEM_WORDS     = 2 * WORDS_PER_IMG
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        go,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  frame_pkg::word_t            in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output frame_pkg::word_t            out_data,
    output logic                        busy,
    output logic                        done,
    output logic                        addr_err,
    input  logic [frame_pkg::ADDR_W-1:0] acc_addr,
    output frame_pkg::word_t            acc_dataR,
    input  frame_pkg::word_t            acc_dataW,
    input  logic                        acc_en,
    input  logic                        acc_we,
    output logic                        acc_start,
    input  logic                        acc_finish
);

    import frame_pkg::*;

    state_t            state;
    logic [ADDR_W-1:0] load_cnt;
    logic [ADDR_W-1:0] rd_ptr;
    logic              rd_all;
    logic              rd_vld_p1;
    logic              acc_rd_p1;
    logic              acc_zero_p1;
    logic [1:0]        buf_cnt;
    logic [2:0]        occ;
    word_t             buf1;
    word_t             acc_hold;
    word_t             ram_rdata;
    word_t             ram_wdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_en;
    logic              ram_we;
    logic              load_fire;
    logic              acc_in_range;
    logic              acc_rd;
    logic              pop;
    logic              push;
    logic              issue;
    logic              last_pop;

    assign load_fire    = (state == LOAD) && in_valid && in_ready;
    assign acc_in_range = acc_addr < ADDR_W'(MEM_WORDS);
    assign acc_rd       = (state == RUN) && acc_en && !acc_we;
    assign out_valid    = (buf_cnt != 2'd0);
    assign pop          = out_valid && out_ready;
    assign push         = rd_vld_p1;

    // Occupancy the buffer will have next cycle if nothing else pops; a read is only issued when it fits.
    assign occ      = 3'(buf_cnt) + 3'(rd_vld_p1) - 3'(pop);
    assign issue    = (state == DUMP) && !rd_all && (occ < 3'd2);
    assign last_pop = pop && rd_all && !rd_vld_p1 && (buf_cnt == 2'd1);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = load_cnt;
        ram_wdata = in_data;
        case (state)
            LOAD: begin
                ram_en = load_fire;
                ram_we = 1'b1;
            end
            RUN: begin
                ram_en    = acc_en && acc_in_range;
                ram_we    = acc_we;
                ram_addr  = acc_addr;
                ram_wdata = acc_dataW;
            end
            DUMP: begin
                ram_en   = issue;
                ram_addr = rd_ptr;
            end
            default: ;
        endcase
    end

    frame_ram #(
        .DATA_W (32),
        .ADDR_W (ADDR_W),
        .DEPTH  (MEM_WORDS)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            load_cnt  <= '0;
            rd_ptr    <= '0;
            rd_all    <= 1'b0;
            rd_vld_p1 <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            acc_start <= 1'b0;
        end else begin
            rd_vld_p1 <= issue;
            case (state)
                IDLE, DONE: begin
                    if (go) begin
                        state    <= LOAD;
                        load_cnt <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        if (load_cnt == ADDR_W'(WORDS_PER_IMG - 1)) begin
                            state     <= RUN;
                            in_ready  <= 1'b0;
                            acc_start <= 1'b1;
                        end else begin
                            load_cnt <= load_cnt + ADDR_W'(1);
                        end
                    end
                end
                RUN: begin
                    if (acc_finish) begin
                        state     <= WAIT_LOW;
                        acc_start <= 1'b0;
                    end
                end
                WAIT_LOW: begin
                    if (!acc_finish) begin
                        state  <= DUMP;
                        rd_ptr <= ADDR_W'(WORDS_PER_IMG);
                        rd_all <= 1'b0;
                    end
                end
                DUMP: begin
                    if (issue) begin
                        if (rd_ptr == ADDR_W'(MEM_WORDS - 1)) begin
                            rd_all <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + ADDR_W'(1);
                        end
                    end
                    if (last_pop) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // p1 -> output buffer: out_data is the head entry, buf1 the overflow slot
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buf_cnt  <= 2'd0;
            out_data <= '0;
        end else begin
            buf_cnt <= buf_cnt + 2'(push) - 2'(pop);
            if (push && ((buf_cnt == 2'd0) || (pop && (buf_cnt == 2'd1)))) begin
                out_data <= ram_rdata;
            end else if (pop) begin
                out_data <= buf1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && ((!pop && (buf_cnt == 2'd1)) || (pop && (buf_cnt == 2'd2)))) begin
            buf1 <= ram_rdata;
        end
    end

    // p1 -> accelerator read return; idle cycles replay the last value, out-of-range reads return zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_rd_p1   <= 1'b0;
            acc_zero_p1 <= 1'b0;
            acc_hold    <= '0;
        end else begin
            acc_rd_p1   <= acc_rd && acc_in_range;
            acc_zero_p1 <= acc_rd && !acc_in_range;
            acc_hold    <= (state == RUN) ? acc_dataR : '0;
        end
    end

    always_comb begin
        acc_dataR = '0;
        if (state == RUN) begin
            if (acc_zero_p1) begin
                acc_dataR = '0;
            end else if (acc_rd_p1) begin
                acc_dataR = ram_rdata;
            end else begin
                acc_dataR = acc_hold;
            end
        end
    end

`ifdef FRAME_MEM_ADDR_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_err <= 1'b0;
        end else if (go && ((state == IDLE) || (state == DONE))) begin
            addr_err <= 1'b0;
        end else if (((state == RUN) && acc_en && !acc_in_range) ||
                     (acc_en && acc_we && (acc_addr < ADDR_W'(WORDS_PER_IMG)))) begin
            addr_err <= 1'b1;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

endmodule

// File: tb/tb_frame_mem_host.sv
// Scoreboard bench for frame_mem_host on a reduced 16-word image: load, inverting accelerator, dump.
module tb_frame_mem_host;

    localparam int W = 16;
    localparam int M = 2 * W;
`ifdef FRAME_MEM_ADDR_CHECK_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        go = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic        busy;
    logic        done;
    logic        addr_err;
    logic [15:0] acc_addr = '0;
    logic [31:0] acc_dataR;
    logic [31:0] acc_dataW = '0;
    logic        acc_en = 1'b0;
    logic        acc_we = 1'b0;
    logic        acc_start;
    logic        acc_finish = 1'b0;

    int          compared = 0;
    int          mismatched = 0;
    int          n_out = 0;
    int          cyc = 0;
    bit          bp_mode = 1'b0;
    logic [31:0] mon_e;
    logic [31:0] exp_q[$];
    logic [31:0] frame_words [0:W-1];

    logic [31:0] src_tab [0:15] = '{
        32'h00FF1080, 32'h00000000, 32'hFFFFFFFF, 32'h12345678,
        32'hA5A5A5A5, 32'h0F0F0F0F, 32'h80000001, 32'h01020304,
        32'hDEADBEEF, 32'hCAFEF00D, 32'h13579BDF, 32'h2468ACE0,
        32'h7F7F7F7F, 32'h00010203, 32'hFEDCBA98, 32'h55AA33CC};
    logic [31:0] exp_tab [0:15] = '{
        32'hFF00EF7F, 32'hFFFFFFFF, 32'h00000000, 32'hEDCBA987,
        32'h5A5A5A5A, 32'hF0F0F0F0, 32'h7FFFFFFE, 32'hFEFDFCFB,
        32'h21524110, 32'h35010FF2, 32'hECA86420, 32'hDB97531F,
        32'h80808080, 32'hFFFEFDFC, 32'h01234567, 32'hAA55CC33};

    frame_mem_host #(
        .WORDS_PER_IMG (W),
        .MEM_WORDS     (M)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .go         (go),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .addr_err   (addr_err),
        .acc_addr   (acc_addr),
        .acc_dataR  (acc_dataR),
        .acc_dataW  (acc_dataW),
        .acc_en     (acc_en),
        .acc_we     (acc_we),
        .acc_start  (acc_start),
        .acc_finish (acc_finish)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result-stream monitor: each accepted word is popped against the scoreboard queue.
    initial forever begin
        @(negedge clk);
        if (!reset && out_valid && out_ready) begin
            n_out++;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL out_extra: got %h with nothing expected", out_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (out_data !== mon_e) begin
                    mismatched++;
                    $display("FAIL out_word[%0d]: got %h expected %h", n_out - 1, out_data, mon_e);
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        out_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got %0d compared expected completion", compared);
        $fatal(1, "watchdog");
    end

    task automatic load_frame(input int go_at);
        int   i = 0;
        int   g = 0;
        int   extra = 0;
        logic hs;
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("busy_after_go", busy, 1);
        chk("in_ready_after_go", in_ready, 1);
        chk("done_after_go", done, 0);
        chk("addr_err_after_go", addr_err, 0);
        while (i < W && g < 4 * W) begin
            in_valid = 1'b1;
            in_data  = frame_words[i];
            go       = (i == go_at);
            @(negedge clk);
            hs = in_ready;
            tick();
            if (hs) i++;
            g++;
        end
        go = 1'b0;
        chk("load_handshakes", i, W);
        chk("acc_start_after_last", acc_start, 1);
        chk("in_ready_after_last", in_ready, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (in_ready) extra++;
            tick();
        end
        in_valid = 1'b0;
        chk("extra_handshakes", extra, 0);
    endtask

    task automatic run_accel(input int mode);
        int          g = 0;
        logic [31:0] d;
        while (!acc_start && g < 50) begin
            tick();
            g++;
        end
        chk("acc_start_seen", acc_start, 1);
        if (mode == 1) begin
            go = 1'b1;
            tick();
            go = 1'b0;
            chk("go_in_run_busy", busy, 1);
            chk("go_in_run_start", acc_start, 1);
            chk("go_in_run_in_ready", in_ready, 0);
        end
        for (int i = 0; i < W; i++) begin
            acc_en   = 1'b1;
            acc_we   = 1'b0;
            acc_addr = 16'(i);
            tick();
            d         = acc_dataR;
            acc_we    = 1'b1;
            acc_addr  = 16'(W + i);
            acc_dataW = ~d;
            tick();
        end
        acc_en = 1'b0;
        acc_we = 1'b0;
        if (mode != 0) begin
            chk("addr_err_clean_run", addr_err, 0);
            if (mode == 1) begin
                acc_en    = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = 16'd3;
                acc_dataW = frame_words[3];
                tick();
                acc_en = 1'b0;
                acc_we = 1'b0;
                chk("addr_err_src_write", addr_err, ERR_EXP);
                tick();
                tick();
                chk("addr_err_sticky", addr_err, ERR_EXP);
            end
            acc_en   = 1'b1;
            acc_addr = 16'd5;
            tick();
            chk("acc_read_src5", acc_dataR, frame_words[5]);
            acc_en = 1'b0;
            tick();
            chk("acc_read_hold", acc_dataR, frame_words[5]);
            acc_en   = 1'b1;
            acc_addr = 16'd50688;
            tick();
            chk("acc_read_oor", acc_dataR, 0);
            acc_en = 1'b0;
            tick();
            chk("addr_err_oor", addr_err, ERR_EXP);
        end
        acc_finish = 1'b1;
        tick();
        chk("acc_start_low", acc_start, 0);
        chk("acc_dataR_outside_run", acc_dataR, 0);
        tick();
        tick();
        chk("no_dump_while_finish", out_valid, 0);
        acc_finish = 1'b0;
        tick();
        tick();
        chk("dump_latency_early", out_valid, 0);
        tick();
        chk("dump_latency_valid", out_valid, 1);
    endtask

    task automatic wait_done();
        int g = 0;
        while (!done && g < 1000) begin
            tick();
            g++;
        end
        chk("done_reached", done, 1);
        chk("busy_in_done", busy, 0);
        chk("out_word_count", n_out, W);
        chk("scoreboard_drained", exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_acc_dataR", acc_dataR, 0);
        chk("rst_acc_start", acc_start, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick();

        // Frame 1: hand table, free-running dump, go pulsed mid-load and mid-run.
        n_out = 0;
        for (int i = 0; i < W; i++) begin
            frame_words[i] = src_tab[i];
            exp_q.push_back(exp_tab[i]);
        end
        load_frame(8);
        run_accel(1);
        wait_done();
        chk("addr_err_in_done", addr_err, ERR_EXP);

        // Frame 2: reversed table, out_ready high one cycle in three.
        n_out   = 0;
        bp_mode = 1'b1;
        for (int i = 0; i < W; i++) begin
            frame_words[i] = src_tab[W - 1 - i];
            exp_q.push_back(exp_tab[W - 1 - i]);
        end
        load_frame(-1);
        run_accel(2);
        wait_done();
        bp_mode = 1'b0;

        // Frame 3: reset while the accelerator holds the RAM.
        for (int i = 0; i < W; i++) frame_words[i] = 32'(i) * 32'h01010101;
        load_frame(-1);
        repeat (1000) tick();
        reset = 1'b1;
        #1;
        chk("mid_run_rst_acc_start", acc_start, 0);
        chk("mid_run_rst_busy", busy, 0);
        chk("mid_run_rst_in_ready", in_ready, 0);
        tick();
        reset = 1'b0;
        tick();
        chk("after_rst_busy", busy, 0);
        chk("after_rst_done", done, 0);

        // Frame 4: counting data after the abort.
        n_out = 0;
        for (int i = 0; i < W; i++) begin
            frame_words[i] = 32'(i);
            exp_q.push_back(~32'(i));
        end
        load_frame(-1);
        run_accel(0);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
